// File: rtl/dpram_port_arb_if.sv
// Signal bundle for dpram_port_arb: two requester ports, the shared RAM port and status.
// master = requesters plus RAM (drive requests and ram_q); slave = the arbiter.
interface dpram_port_arb_if #(
  parameter int depth = 8,
  parameter int width = 32
);

  logic             req0_valid;
  logic             req0_we;
  logic [depth-1:0] req0_addr;
  logic [width-1:0] req0_wdata;
  logic             req0_ack;
  logic             req0_rvalid;
  logic [width-1:0] req0_rdata;

  logic             req1_valid;
  logic             req1_we;
  logic [depth-1:0] req1_addr;
  logic [width-1:0] req1_wdata;
  logic             req1_ack;
  logic             req1_rvalid;
  logic [width-1:0] req1_rdata;

  logic             ram_wren;
  logic [depth-1:0] ram_address;
  logic [width-1:0] ram_data;
  logic [width-1:0] ram_q;

  logic             busy;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ack, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ack, req1_rvalid, req1_rdata,
    input  ram_wren, ram_address, ram_data,
    output ram_q,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ack, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ack, req1_rvalid, req1_rdata,
    output ram_wren, ram_address, ram_data,
    input  ram_q,
    output busy
  );

endinterface

// File: rtl/dpram_port_arb.sv
// Shares one synchronous RAM port between two requesters: ack in N+1, write at end of N+1, read data in N+3.
// Requesters hold valid until ack; define DPRAM_ARB_RR_EN for round-robin on contention, else req0 has fixed priority.
module dpram_port_arb #(
  parameter int depth = 8,
  parameter int width = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dpram_port_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic [depth-1:0] addr;
    logic [width-1:0] wdata;
  } acc_t;

  state_e           state_q, state_d;
  logic             ram_wren_q, ram_wren_d;
  logic [depth-1:0] ram_addr_q, ram_addr_d;
  logic [width-1:0] ram_data_q, ram_data_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic [width-1:0] rdata0_q, rdata0_d;
  logic [width-1:0] rdata1_q, rdata1_d;
  logic             owner_q, owner_d;

  logic             grant_any;
  logic             grant_sel;
  acc_t             req0_acc, req1_acc, win_acc;

  assign req0_acc  = {bus.req0_we, bus.req0_addr, bus.req0_wdata};
  assign req1_acc  = {bus.req1_we, bus.req1_addr, bus.req1_wdata};
  assign grant_any = bus.req0_valid | bus.req1_valid;
  assign win_acc   = grant_sel ? req1_acc : req0_acc;

`ifdef DPRAM_ARB_RR_EN
  // last_q names the requester granted most recently; it loses the next tie.
  logic last_q, last_d;

  always_comb begin
    grant_sel = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_sel = ~last_q;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && grant_any) begin
      last_d = grant_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant_sel = bus.req1_valid & ~bus.req0_valid;
`endif

  always_comb begin
    state_d    = state_q;
    ram_wren_d = ram_wren_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    owner_d    = owner_q;

    case (state_q)
      IDLE: begin
        ram_wren_d = 1'b0;
        if (grant_any) begin
          owner_d    = grant_sel;
          ram_addr_d = win_acc.addr;
          ram_data_d = win_acc.wdata;
          ram_wren_d = win_acc.we;
          ack0_d     = ~grant_sel;
          ack1_d     = grant_sel;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // ram_wren_q still carries the accepted access type here.
        ram_wren_d = 1'b0;
        state_d    = ram_wren_q ? IDLE : RDATA;
      end
      RDATA: begin
        ram_wren_d = 1'b0;
        if (owner_q) begin
          rdata1_d  = bus.ram_q;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = bus.ram_q;
          rvalid0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        ram_wren_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ram_wren_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      owner_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_wren_q <= ram_wren_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      owner_q    <= owner_d;
    end
  end

  assign bus.req0_ack    = ack0_q;
  assign bus.req1_ack    = ack1_q;
  assign bus.req0_rvalid = rvalid0_q;
  assign bus.req1_rvalid = rvalid1_q;
  assign bus.req0_rdata  = rdata0_q;
  assign bus.req1_rdata  = rdata1_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.ram_address = ram_addr_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.busy        = (state_q != IDLE);

  a_ack_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(ack0_q && ack1_q));
  a_rvalid_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(rvalid0_q && rvalid1_q));
  a_wren_issue: assert property (@(posedge clk_i) disable iff (rst_i) ram_wren_q |-> (state_q == ISSUE));

endmodule

// File: tb/tb_dpram_port_arb.sv
// Randomized plus directed bench for dpram_port_arb against a cycle-schedule reference model.
module tb_dpram_port_arb;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpram_port_arb_if #(.depth(AW), .width(DW)) bus ();

  dpram_port_arb #(.depth(AW), .width(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Synchronous RAM behind the arbiter: registered read, write on wren.
  bit [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_address];
  end

  typedef struct {
    bit          we;
    bit [AW-1:0] addr;
    bit [DW-1:0] wdata;
    bit          rnd;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];
  cmd_t cur[2];
  bit   act[2];

  // Reference model: expected output schedule per cycle plus abstract bookkeeping.
  bit          e_ack [2][NC+8];
  bit          e_rv  [2][NC+8];
  bit [DW-1:0] e_rdv [2][NC+8];
  bit          e_wren[NC+8];
  bit [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit [AW-1:0] m_addr;
  bit [DW-1:0] m_data;
  bit [DW-1:0] m_rd[2];
  bit          last;
  int          free_t;
  int          wr_issue_t;
  int          rdata_t;
  int          grants[$];

  int t;
  int n_tests;
  int n_fail;
  bit force_rst_now;
  bit force_rst_at_rdata;
  bit rand_rst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, t, got, exp);
    end
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.we    = 1'($urandom_range(0, 1));
    c.addr  = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8'hFF : 8'h00)
                                          : 8'($urandom);
    c.wdata = $urandom;
    c.rnd   = 1'b1;
    return c;
  endfunction

  task automatic drive_bus();
    bus.req0_valid = act[0];
    bus.req0_we    = cur[0].we;
    bus.req0_addr  = cur[0].addr;
    bus.req0_wdata = cur[0].wdata;
    bus.req1_valid = act[1];
    bus.req1_we    = cur[1].we;
    bus.req1_addr  = cur[1].addr;
    bus.req1_wdata = cur[1].wdata;
  endtask

  task automatic drive();
    int k;
    rst = force_rst_now;
    force_rst_now = 1'b0;
    if (force_rst_at_rdata && t == rdata_t) begin
      rst = 1'b1;
      force_rst_at_rdata = 1'b0;
    end else if (rand_rst && t != wr_issue_t && $urandom_range(0, 199) == 0) begin
      rst = 1'b1;
    end
    for (int r = 0; r < 2; r++) begin
      if (act[r] && e_ack[r][t]) act[r] = 1'b0;
      if (act[r] && cur[r].rnd) begin
        k = $urandom_range(0, 15);
        if (k == 0) act[r] = 1'b0;
        else if (k < 3) begin
          cur[r].we    = 1'($urandom_range(0, 1));
          cur[r].addr  = 8'($urandom);
          cur[r].wdata = $urandom;
        end
      end
      if (!act[r]) begin
        if (r == 0 && q0.size() > 0 && (!q0[0].rnd || $urandom_range(0, 2) != 0)) begin
          cur[0] = q0.pop_front();
          act[0] = 1'b1;
        end
        if (r == 1 && q1.size() > 0 && (!q1[0].rnd || $urandom_range(0, 2) != 0)) begin
          cur[1] = q1.pop_front();
          act[1] = 1'b1;
        end
      end
    end
    drive_bus();
  endtask

  task automatic model();
    bit   win;
    cmd_t c;
    if (rst) begin
      free_t = t + 1;
      last   = 1'b1;
      m_addr = '0;
      m_data = '0;
      m_rd[0] = '0;
      m_rd[1] = '0;
      wr_issue_t = -1;
      rdata_t    = -1;
      for (int k = t + 1; k <= t + 4; k++) begin
        e_ack[0][k] = 1'b0;
        e_ack[1][k] = 1'b0;
        e_rv[0][k]  = 1'b0;
        e_rv[1][k]  = 1'b0;
        e_wren[k]   = 1'b0;
      end
    end else if (t >= free_t && (act[0] || act[1])) begin
      if (act[0] && act[1]) begin
`ifdef DPRAM_ARB_RR_EN
        win = ~last;
`else
        win = 1'b0;
`endif
      end else begin
        win = act[1];
      end
      c    = cur[win];
      last = win;
      grants.push_back(int'(win));
      e_ack[win][t+1] = 1'b1;
      m_addr = c.addr;
      m_data = c.wdata;
      if (c.we) begin
        ref_mem[c.addr] = c.wdata;
        e_wren[t+1]     = 1'b1;
        free_t          = t + 2;
        wr_issue_t      = t + 1;
      end else begin
        e_rv[win][t+3]  = 1'b1;
        e_rdv[win][t+3] = ref_mem[c.addr];
        free_t          = t + 3;
        rdata_t         = t + 2;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
    for (int r = 0; r < 2; r++) if (e_rv[r][t]) m_rd[r] = e_rdv[r][t];
    check("ack0",    bus.req0_ack,    e_ack[0][t]);
    check("ack1",    bus.req1_ack,    e_ack[1][t]);
    check("rvalid0", bus.req0_rvalid, e_rv[0][t]);
    check("rvalid1", bus.req1_rvalid, e_rv[1][t]);
    check("rdata0",  bus.req0_rdata,  m_rd[0]);
    check("rdata1",  bus.req1_rdata,  m_rd[1]);
    check("busy",    bus.busy,        t < free_t);
    check("ram_wren", bus.ram_wren,   e_wren[t]);
    check("ram_addr", bus.ram_address, m_addr);
    check("ram_data", bus.ram_data,   m_data);
    drive();
    model();
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] || t < free_t) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, n < budget, 1);
  endtask

  function automatic cmd_t mk(input bit we, input bit [AW-1:0] a, input bit [DW-1:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d; c.rnd = 1'b0;
    return c;
  endfunction

  initial begin
    bit exp_g [8];
    t = 0; n_tests = 0; n_fail = 0;
    rst = 1'b1;
    act[0] = 1'b0; act[1] = 1'b0;
    cur[0] = mk(1'b0, '0, '0);
    cur[1] = mk(1'b0, '0, '0);
    rand_rst = 1'b0; force_rst_at_rdata = 1'b0;
    free_t = 0; last = 1'b1;
    drive_bus();
    model();
    force_rst_now = 1'b1;
    step();
    step();

    // Single write then read on requester 0.
    q0.push_back(mk(1'b1, 8'h05, 32'hDEADBEEF));
    q0.push_back(mk(1'b0, 8'h05, 32'h0));
    run_drain("wr_rd", 40);
    check("wr_rd_rdata0", bus.req0_rdata, 32'hDEADBEEF);
    check("wr_rd_rdata1", bus.req1_rdata, 32'h0);

    // Top address on requester 1 while requester 0 reads address 0.
    q1.push_back(mk(1'b1, 8'hFF, 32'h12345678));
    q1.push_back(mk(1'b0, 8'hFF, 32'h0));
    q0.push_back(mk(1'b0, 8'h00, 32'h0));
    run_drain("boundary", 40);
    check("boundary_rdata1", bus.req1_rdata, 32'h12345678);
    check("boundary_rdata0", bus.req0_rdata, 32'h0);
    check("boundary_mem0",   mem[0],         32'h0);

    // Fresh reset, then sustained contention of reads.
    force_rst_now = 1'b1;
    step();
    step();
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 8'h10, 32'h0));
      q1.push_back(mk(1'b0, 8'h20, 32'h0));
    end
    run_drain("contend", 80);
`ifdef DPRAM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    check("contend_ngrants", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++) check("contend_grant", grants[i], exp_g[i]);

    // Reset while a read sits in its data-return cycle, then a clean read.
    q1.push_back(mk(1'b1, 8'h33, 32'hA5A50001));
    run_drain("mid_rst_wr", 20);
    q1.push_back(mk(1'b0, 8'h33, 32'h0));
    force_rst_at_rdata = 1'b1;
    run_drain("mid_rst_rd", 20);
    check("mid_rst_aborted", bus.req1_rdata, 32'h0);
    q1.push_back(mk(1'b0, 8'h33, 32'h0));
    run_drain("post_rst_rd", 20);
    check("post_rst_rdata1", bus.req1_rdata, 32'hA5A50001);

    // Random traffic with withdrawals, field changes and occasional resets.
    rand_rst = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if (q0.size() < 2) q0.push_back(rnd_cmd());
      if (q1.size() < 2) q1.push_back(rnd_cmd());
      step();
    end
    rand_rst = 1'b0;
    run_drain("rand_drain", 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
